// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM states and
// the width of one receive FIFO entry.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_e;

    // Entry layout is {frame_err, parity_err, data}
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy output; a pop frees space for a
// push in the same cycle, so a full FIFO accepts push+pop together.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = valid_o ? mem_q[rd_q] : '0;
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (5..9 data bits, optional parity, 1 or 2 stop
// bits) with a show-ahead receive FIFO and sticky overrun flag.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DIV_W-1:0]             cfg_div,
    input  logic                         rx_en,
    input  logic                         ser_rx,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic                         rd_parity_err,
    output logic                         rd_frame_err,
    output logic                         overrun,
    input  logic                         overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         rx_busy
);
    localparam int EW = entry_width(DATA_BITS);

    logic                 sync1_q, sync2_q, prev_q;
    logic                 fall, sample, tick, last_stop;
    rx_state_e            state_q;
    logic [DIV_W-1:0]     div_q, cnt_q, div_eff;
    logic [3:0]           bit_q;
    logic                 stop_q, perr_q, ferr_q, push_q, overrun_q;
    logic [DATA_BITS-1:0] data_q;
    logic [EW-1:0]        push_entry_q, head;
    logic                 full, pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= ser_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall      = !sync2_q && prev_q;
    assign sample    = sync2_q;
    assign tick      = (cnt_q == DIV_W'(1));
    assign div_eff   = (cfg_div < DIV_W'(4)) ? DIV_W'(4) : cfg_div;
    assign last_stop = (STOP_BITS == 1) || stop_q;
    assign rx_busy   = (state_q != ST_IDLE);

    // Counter counts down to 1; the sample is taken on the cycle it reads 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (!rx_en) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (fall) begin
                            div_q   <= div_eff;
                            cnt_q   <= div_eff >> 1;
                            state_q <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            if (sample) begin
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_DATA;
                                cnt_q   <= div_q;
                                bit_q   <= '0;
                                perr_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            data_q <= {sample, data_q[DATA_BITS-1:1]};
                            cnt_q  <= div_q;
                            if (bit_q == 4'(DATA_BITS - 1)) begin
                                state_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                                stop_q  <= 1'b0;
                                ferr_q  <= 1'b0;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_PAR: begin
                        if (tick) begin
                            perr_q  <= ((^data_q) ^ sample) != (PARITY == PAR_ODD);
                            cnt_q   <= div_q;
                            state_q <= ST_STOP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (tick) begin
                            if (last_stop) begin
                                push_q       <= 1'b1;
                                push_entry_q <= {ferr_q | !sample, perr_q, data_q};
                                state_q      <= ST_IDLE;
                            end else begin
                                ferr_q <= ferr_q | !sample;
                                stop_q <= 1'b1;
                                cnt_q  <= div_q;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_q),
        .push_data_i (push_entry_q),
        .pop_i       (rd_ready),
        .valid_o     (rd_valid),
        .full_o      (full),
        .head_o      (head),
        .level_o     (fifo_level)
    );

    assign pop           = rd_valid && rd_ready;
    assign rd_data       = head[DATA_BITS-1:0];
    assign rd_parity_err = head[DATA_BITS];
    assign rd_frame_err  = head[DATA_BITS+1];
    assign overrun       = overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (push_q && full && !pop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with on-board receive FIFO, the successor to the fixed 8N1 bit-sampling serial monitor used in PicoSoC simulation. It oversamples `ser_rx` with a runtime-programmable divider and supports 5–9 data bits, optional parity, and one or two stop bits. It flags parity, framing and overrun errors and buffers received frames for a valid/ready consumer. It sits between the SoC serial pin and the UART register interface, and it is also instantiated in benches as a self-checking serial monitor.

## Interface
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `DIV_W`, 16: width of `cfg_div`.
- `FIFO_DEPTH`, 8: entries, power of two, ≥2.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cfg_div` in DIV_W: clock cycles per bit; values <4 treated as 4.
- `rx_en` in 1: receiver enable.
- `ser_rx` in 1: asynchronous serial input, idle high.
- `rd_valid` out 1: FIFO non-empty.
- `rd_ready` in 1: consumer pops head when `rd_valid && rd_ready`.
- `rd_data` out DATA_BITS: head entry data, LSB = first bit received.
- `rd_parity_err` out 1: head entry parity error.
- `rd_frame_err` out 1: head entry framing error.
- `overrun` out 1: sticky; a frame was dropped because the FIFO was full.
- `overrun_clr` in 1: clears `overrun`. A simultaneous new overrun wins.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: occupied entries.
- `rx_busy` out 1: FSM not in IDLE.

## Operation
- Input path: 2-flop synchroniser with reset value 1, plus a 1-flop previous-value register. A falling edge is sync==0 && prev==1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on a falling edge with `rx_en`=1, latch `div` = max(cfg_div,4), load counter with `div>>1`, go to START.
  - START: at counter expiry, sample the line. If 1 (glitch/false start) → IDLE, no push. If 0 → DATA, counter = `div`, bit index = 0.
  - DATA: at each expiry, shift the sample in LSB-first. After DATA_BITS samples → PAR if PARITY≠0, else STOP.
  - PAR: sample. parity_err = (XOR(data) ^ sample) ≠ expected. Expected is 1 for odd, 0 for even.
  - STOP: sample each stop bit. frame_err = any stop sample ==0. The entry is pushed at the final stop sample; the FSM then returns to IDLE in the same transition. A frame with frame_err is still pushed.
- `rx_en`=0: FSM forced to IDLE next cycle, and a partial frame is discarded. FIFO contents and `overrun` are kept.
- FIFO entry = {frame_err, parity_err, data}. Show-ahead: head is visible on `rd_*` whenever `rd_valid`=1.
  - Push is accepted if the FIFO is not full, or a pop occurs in the same cycle. At full with push and pop together, both happen and the level stays at DEPTH.
  - Push at full with no pop: frame dropped, `overrun` set.
  - Pointers wrap modulo FIFO_DEPTH. The level counter saturates at neither bound, because it is exact by construction.
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_parity_err`=0, `rd_frame_err`=0, `overrun`=0, `fifo_level`=0, `rx_busy`=0. Synchroniser flops are 1.

## Timing
- Edge detect occurs 2 cycles after the pin transition (synchroniser), plus 1 cycle for the edge register.
- Let cycle E be the cycle in which IDLE sees the edge:
  - start sample at E + (div>>1);
  - data bit i sample at E + (div>>1) + (i+1)·div;
  - parity sample, then stop samples, follow at further `div` intervals.
- Push is registered on the final stop sample cycle. `rd_valid` and `fifo_level` update on the next rising edge.
- A new falling edge is accepted from the cycle after the return to IDLE. Back-to-back frames with one stop bit are therefore received.
- A pop updates `rd_*` and `fifo_level` at the next edge.
- `cfg_div` changes mid-frame have no effect until the next start.

## Structure
- Package `uart_pkg`: parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN), FSM state enum, and a function giving entry width = DATA_BITS+2.
- Sub-module `uart_sync_fifo` (parametrised width/depth, show-ahead, level output). The FSM, divider counter and synchroniser stay in the top.

## Test plan
- 8N1, cfg_div=16: send 0x55 then 0xA3 back-to-back → two entries 0x55, 0xA3, both error flags 0, `fifo_level`=2.
- DATA_BITS=7, PARITY=2 (even), cfg_div=10: send 0x41 with the parity bit inverted → `rd_data`=0x41, `rd_parity_err`=1, `rd_frame_err`=0.
- 8N1: send 0x00 with stop bit held low, then idle high → entry 0x00, `rd_frame_err`=1. A following 0x7E frame is received clean.
- 3-cycle low glitch with cfg_div=16 → no push, `rx_busy` returns to 0 within 8 cycles after the edge is detected.
- FIFO_DEPTH=8, `rd_ready`=0, 9 frames 0x01..0x09 → level 8, `overrun`=1, head 0x01, and 0x09 is absent. Repeat with `rd_ready`=1 asserted exactly at the 9th push → 0x09 stored, `overrun` stays 0, level 8. Then `overrun_clr` clears the sticky flag.
- `reset` asserted mid-DATA of frame 0x3C → all outputs at reset values immediately. After release, 0x3C resent → received correctly.
